// File: rtl/adc128s022_responder.sv
// adc128s022_responder: device-side SPI model of an 8-channel serial ADC.
// Define ADC_RESP_ERRCHK_EN to add the err_short / err_cnt abort diagnostics.
`timescale 1ns/1ps
module adc128s022_responder #(
    parameter int         DATA_W      = 12,
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] RESET_ADDR  = 3'd0
) (
    input  logic                  clk_50M,
    input  logic                  rst,
    input  logic                  adc_sck,
    input  logic                  adc_cs_n,
    input  logic                  din,
    input  logic [8*DATA_W-1:0]   ch_data,
    output logic                  dout,
    output logic                  dout_oe,
    output logic [2:0]            cur_addr,
`ifdef ADC_RESP_ERRCHK_EN
    output logic                  err_short,
    output logic [7:0]            err_cnt,
`endif
    output logic                  frame_done
);
    localparam int FRAME_W = DATA_W + 4;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_A2   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_A1   = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_A0   = CNT_W'(4);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   sck_q;
    logic                   cs_q;
    logic                   sck_s;
    logic                   cs_s;
    logic                   din_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_rise;
    logic                   cs_fall;
    logic [FRAME_W-1:0]     shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [2:0]             next_addr;
    logic [DATA_W-1:0]      sample;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign din_s    = din_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_rise  = cs_s & ~cs_q;
    assign cs_fall  = ~cs_s & cs_q;
    // the new frame's channel is next_addr, so that is what gets snapshotted
    assign sample   = ch_data[next_addr*DATA_W +: DATA_W];

    // Bring the SPI pins into clk_50M and keep one delayed copy for edges.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            din_sync <= '0;
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc_sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            din_sync <= {din_sync[SYNC_STAGES-2:0], din};
            sck_q    <= sck_s;
            cs_q     <= cs_s;
        end
    end

    // Frame FSM: address capture on rises, data shift on falls.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dout       <= 1'b0;
            dout_oe    <= 1'b0;
            cur_addr   <= RESET_ADDR;
            next_addr  <= RESET_ADDR;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    dout_oe <= 1'b0;
                    dout    <= 1'b0;
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        cur_addr <= next_addr;
                        shreg    <= {4'b0, sample};
                        bit_cnt  <= '0;
                        dout_oe  <= 1'b1;
                        dout     <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        dout_oe <= 1'b0;
                        dout    <= 1'b0;
                    end else if (sck_rise) begin
                        if (bit_cnt != CNT_LAST) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_A2) next_addr[2] <= din_s;
                            if (bit_cnt == CNT_A1) next_addr[1] <= din_s;
                            if (bit_cnt == CNT_A0) next_addr[0] <= din_s;
                            if (bit_cnt == CNT_PEN) frame_done <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt == CNT_LAST) begin
                            // continuous mode: this fall opens the next frame
                            cur_addr <= next_addr;
                            shreg    <= {4'b0, sample};
                            bit_cnt  <= '0;
                            dout     <= 1'b0;
                        end else begin
                            shreg <= shreg << 1;
                            dout  <= shreg[FRAME_W-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_RESP_ERRCHK_EN
    logic short_abort;

    assign short_abort = (state == ACTIVE) && cs_rise &&
                         (bit_cnt != '0) && (bit_cnt != CNT_LAST);

    // Sticky flag and saturating counter of frames cut short by cs_n.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            err_short <= 1'b0;
            err_cnt   <= 8'd0;
        end else if (short_abort) begin
            err_short <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
